// File: rtl/uart_pkg.sv
// Shared UART-side types and widths for the transmit scheduler and its arbiter.
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;
    localparam int unsigned FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } sched_state_e;

    // Round-robin successor of idx within a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping modulo N.
module uart_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int unsigned IDX_W = $clog2(N);

    int unsigned      sum_s;
    logic [IDX_W-1:0] pos_s;
    logic             hit_s;

    // Walk the ring starting at ptr; the first requester found wins.
    always_comb begin
        grant = {N{1'b0}};
        idx   = {IDX_W{1'b0}};
        any   = 1'b0;
        sum_s = 32'd0;
        pos_s = {IDX_W{1'b0}};
        hit_s = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            sum_s        = 32'(ptr) + k;
            pos_s        = (sum_s >= N) ? IDX_W'(sum_s - N) : IDX_W'(sum_s);
            hit_s        = req[pos_s] && !any;
            grant[pos_s] = hit_s;
            idx          = hit_s ? pos_s : idx;
            any          = any | req[pos_s];
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART_TX between NUM_REQ byte requesters.
// Optional build macro UART_SCHED_TIMEOUT_EN adds a WAIT timeout and the sticky_timeout output.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tx_en,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               req_done,
    output logic                             done_err,
    output logic                             tx_start,
    output logic [UART_BYTE_W-1:0]           tx_data,
    input  logic                             tx_done,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic                             busy,
    output logic [FRAME_CNT_W-1:0]           frame_cnt
`ifdef UART_SCHED_TIMEOUT_EN
    ,
    output logic                             sticky_timeout
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned GAP_W = (GAP_CYCLES > 32'd1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 32'd0) ? (GAP_CYCLES - 32'd1) : 32'd0);

    sched_state_e             state_r;
    sched_state_e             state_nxt_s;
    logic [IDX_W-1:0]         rr_ptr_r;
    logic [IDX_W-1:0]         owner_r;
    logic [UART_BYTE_W-1:0]   hold_byte_r;
    logic [GAP_W-1:0]         gap_cnt_r;
    logic [FRAME_CNT_W-1:0]   frame_cnt_r;
    logic                     tx_start_r;
    logic [NUM_REQ-1:0]       req_done_r;
    logic                     done_err_r;
    logic                     busy_r;

    logic [NUM_REQ-1:0]       arb_grant_s;
    logic [IDX_W-1:0]         arb_idx_s;
    logic                     arb_any_s;
    logic [UART_BYTE_W-1:0]   win_byte_s;
    logic [NUM_REQ-1:0]       owner_oh_s;
    logic [NUM_REQ-1:0]       req_ready_s;
    logic                     grant_s;
    logic                     done_ok_s;
    logic                     abort_s;
    logic                     gap_end_s;
    logic                     timeout_hit_s;

    uart_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_r),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .any   (arb_any_s)
    );

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 32'd1);

    logic [TO_W-1:0] wait_cnt_r;
    logic            sticky_timeout_r;

    // WAIT-state cycle counter and sticky timeout flag; only rst clears the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r       <= {TO_W{1'b0}};
            sticky_timeout_r <= 1'b0;
        end else begin
            wait_cnt_r       <= (state_r == ST_WAIT) ? (wait_cnt_r + {{(TO_W-1){1'b0}}, 1'b1}) : {TO_W{1'b0}};
            sticky_timeout_r <= sticky_timeout_r | (abort_s & timeout_hit_s & tx_en);
        end
    end

    assign timeout_hit_s  = (wait_cnt_r == TO_W'(TIMEOUT_CYCLES));
    assign sticky_timeout = sticky_timeout_r;
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Byte of the arbitration winner, selected by the one-hot grant.
    always_comb begin
        win_byte_s = {UART_BYTE_W{1'b0}};
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            win_byte_s = win_byte_s | ({UART_BYTE_W{arb_grant_s[i]}} & req_data[i*UART_BYTE_W +: UART_BYTE_W]);
        end
    end

    // One-hot view of the current owner for the completion pulse.
    always_comb begin
        owner_oh_s          = {NUM_REQ{1'b0}};
        owner_oh_s[owner_r] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_ARB;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Per-state event decode; tx_done beats a simultaneous tx_en drop.
    always_comb begin
        grant_s     = 1'b0;
        done_ok_s   = 1'b0;
        abort_s     = 1'b0;
        gap_end_s   = 1'b0;
        req_ready_s = {NUM_REQ{1'b0}};
        case (state_r)
            ST_ARB: begin
                grant_s     = !rst && tx_en && arb_any_s;
                req_ready_s = grant_s ? arb_grant_s : {NUM_REQ{1'b0}};
            end
            ST_WAIT: begin
                done_ok_s = tx_done;
                abort_s   = !tx_done && (!tx_en || timeout_hit_s);
            end
            ST_GAP: begin
                gap_end_s = (GAP_CYCLES == 32'd0) || (gap_cnt_r == GAP_LAST);
            end
            default: begin
                grant_s = 1'b0;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ARB: begin
                state_nxt_s = grant_s ? ST_LAUNCH : ST_ARB;
            end
            ST_LAUNCH: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_ok_s) begin
                    state_nxt_s = (GAP_CYCLES == 32'd0) ? ST_ARB : ST_GAP;
                end else if (abort_s) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_GAP: begin
                state_nxt_s = gap_end_s ? ST_ARB : ST_GAP;
            end
            default: begin
                state_nxt_s = ST_ARB;
            end
        endcase
    end

    // Holding register, pointers, counters and registered output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r    <= {IDX_W{1'b0}};
            owner_r     <= {IDX_W{1'b0}};
            hold_byte_r <= {UART_BYTE_W{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
            frame_cnt_r <= {FRAME_CNT_W{1'b0}};
            tx_start_r  <= 1'b0;
            req_done_r  <= {NUM_REQ{1'b0}};
            done_err_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (grant_s) begin
                hold_byte_r <= win_byte_s;
                owner_r     <= arb_idx_s;
                rr_ptr_r    <= IDX_W'(rr_next(32'(arb_idx_s), NUM_REQ));
            end
            gap_cnt_r   <= (state_r == ST_GAP) ? (gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1}) : {GAP_W{1'b0}};
            frame_cnt_r <= done_ok_s ? (frame_cnt_r + {{(FRAME_CNT_W-1){1'b0}}, 1'b1}) : frame_cnt_r;
            tx_start_r  <= grant_s;
            req_done_r  <= (done_ok_s || abort_s) ? owner_oh_s : {NUM_REQ{1'b0}};
            done_err_r  <= abort_s;
            busy_r      <= (state_nxt_s != ST_ARB);
        end
    end

    assign req_ready = req_ready_s;
    assign req_done  = req_done_r;
    assign done_err  = done_err_r;
    assign tx_start  = tx_start_r;
    assign tx_data   = hold_byte_r;
    assign grant_id  = owner_r;
    assign busy      = busy_r;
    assign frame_cnt = frame_cnt_r;

endmodule
